// File: rtl/bus_timer_if.sv
// Data-bus slave port of the bus timer: select, direction, address, byte enables and data.
interface bus_timer_if;
    logic        ce;
    logic        we;
    logic [31:0] addr;
    logic [3:0]  sel;
    logic [31:0] data_i;
    logic [31:0] data_o;

    modport master (output ce, we, addr, sel, data_i, input data_o);
    modport slave  (input ce, we, addr, sel, data_i, output data_o);
endinterface

// File: rtl/bus_timer.sv
// Memory-mapped compare timer with auto-reload and a level interrupt.
// Optional tick prescaler is built in when BUS_TIMER_PRESCALE_EN is defined.
module bus_timer (
    input  logic           clk,
    input  logic           rst,
    bus_timer_if.slave     bus,
    output logic           timer_int_o
);
    localparam logic [2:0] REG_CTRL     = 3'd0;
    localparam logic [2:0] REG_COUNT    = 3'd1;
    localparam logic [2:0] REG_COMPARE  = 3'd2;
    localparam logic [2:0] REG_STATUS   = 3'd3;
    localparam logic [2:0] REG_PRESCALE = 3'd4;

    logic [2:0]  ctrl_reg, ctrl_next;
    logic [31:0] count_reg, count_next;
    logic [31:0] compare_reg, compare_next;
    logic        pend_reg, pend_next;
    logic [15:0] prescale_reg;
`ifdef BUS_TIMER_PRESCALE_EN
    logic [15:0] prescale_next;
    logic [15:0] div_reg, div_next;
    logic        prescale_wr;
`endif

    logic        wr_en;
    logic [2:0]  reg_idx;
    logic        tick;
    logic        hit;
    logic [31:0] byte_mask;
    logic [31:0] ctrl_wdata;
    logic [31:0] count_wdata;
    logic [31:0] compare_wdata;
    logic [31:0] prescale_wdata;
    logic        unused_bits;

    assign wr_en   = bus.ce & bus.we & ~rst;
    assign reg_idx = bus.addr[4:2];

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_byte_mask
            assign byte_mask[8*gi +: 8] = {8{bus.sel[gi]}};
        end
    endgenerate

    // Byte-merged write values: unselected lanes keep the current register contents.
    assign ctrl_wdata     = ({29'd0, ctrl_reg} & ~byte_mask) | (bus.data_i & byte_mask);
    assign count_wdata    = (count_reg & ~byte_mask) | (bus.data_i & byte_mask);
    assign compare_wdata  = (compare_reg & ~byte_mask) | (bus.data_i & byte_mask);
    assign prescale_wdata = ({16'd0, prescale_reg} & ~byte_mask) | (bus.data_i & byte_mask);

    assign unused_bits = ^{bus.addr[31:5], bus.addr[1:0], ctrl_wdata[31:3], prescale_wdata[31:16]};

`ifdef BUS_TIMER_PRESCALE_EN
    assign tick = ctrl_reg[0] & (div_reg == prescale_reg);
`else
    assign tick = ctrl_reg[0];
    assign prescale_reg = 16'd0;
`endif
    assign hit = tick & (count_reg == compare_reg);

    always_comb begin
        ctrl_next    = ctrl_reg;
        count_next   = count_reg;
        compare_next = compare_reg;
        pend_next    = pend_reg;
`ifdef BUS_TIMER_PRESCALE_EN
        prescale_next = prescale_reg;
        prescale_wr   = 1'b0;
`endif
        if (tick) begin
            count_next = (hit && ctrl_reg[1]) ? 32'd0 : count_reg + 32'd1;
        end
        if (hit) begin
            pend_next = 1'b1;
        end
        if (wr_en) begin
            case (reg_idx)
                REG_CTRL:    ctrl_next    = ctrl_wdata[2:0];
                REG_COUNT:   count_next   = count_wdata;
                REG_COMPARE: compare_next = compare_wdata;
                REG_STATUS: begin
                    // A match in this same cycle wins over the clear.
                    if (bus.sel[0] && bus.data_i[0] && !hit) begin
                        pend_next = 1'b0;
                    end
                end
`ifdef BUS_TIMER_PRESCALE_EN
                REG_PRESCALE: begin
                    prescale_next = prescale_wdata[15:0];
                    prescale_wr   = |bus.sel[1:0];
                end
`endif
                default: ;
            endcase
        end
    end

`ifdef BUS_TIMER_PRESCALE_EN
    always_comb begin
        div_next = div_reg + 16'd1;
        if (!ctrl_reg[0] || prescale_wr || (div_reg == prescale_reg)) begin
            div_next = 16'd0;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            ctrl_reg    <= 3'd0;
            count_reg   <= 32'd0;
            compare_reg <= 32'hFFFF_FFFF;
            pend_reg    <= 1'b0;
        end else begin
            ctrl_reg    <= ctrl_next;
            count_reg   <= count_next;
            compare_reg <= compare_next;
            pend_reg    <= pend_next;
        end
    end

`ifdef BUS_TIMER_PRESCALE_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            prescale_reg <= 16'd0;
            div_reg      <= 16'd0;
        end else begin
            prescale_reg <= prescale_next;
            div_reg      <= div_next;
        end
    end
`endif

    always_comb begin
        bus.data_o = 32'd0;
        if (bus.ce && !bus.we) begin
            case (reg_idx)
                REG_CTRL:     bus.data_o = {29'd0, ctrl_reg};
                REG_COUNT:    bus.data_o = count_reg;
                REG_COMPARE:  bus.data_o = compare_reg;
                REG_STATUS:   bus.data_o = {31'd0, pend_reg};
                REG_PRESCALE: bus.data_o = {16'd0, prescale_reg};
                default:      bus.data_o = 32'd0;
            endcase
        end
    end

    // Masked by rst so the request is low throughout the reset cycle itself.
    assign timer_int_o = pend_reg & ctrl_reg[2] & ~rst;
endmodule
